// File: rtl/dsp_2int8_mac_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_2int8_mac_ctrl_if
//  Brief    : Element input, DSP operand/product and result bundle for
//             dsp_2int8_mac_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface dsp_2int8_mac_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_d;
  logic [7:0]       in_b;
  logic             in_last;
  logic [7:0]       dsp_din_a;
  logic [7:0]       dsp_din_d;
  logic [7:0]       dsp_din_b;
  logic [15:0]      dsp_dout_ab;
  logic [15:0]      dsp_dout_db;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc_ab;
  logic [ACC_W-1:0] out_acc_db;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_a, in_d, in_b, in_last,
    input  dsp_dout_ab, dsp_dout_db, out_ready,
    output in_ready, dsp_din_a, dsp_din_d, dsp_din_b,
    output out_valid, out_acc_ab, out_acc_db, out_count
  );

  modport master (
    output in_valid, in_a, in_d, in_b, in_last,
    output dsp_dout_ab, dsp_dout_db, out_ready,
    input  in_ready, dsp_din_a, dsp_din_d, dsp_din_b,
    input  out_valid, out_acc_ab, out_acc_db, out_count
  );
endinterface
`default_nettype wire

// File: rtl/dsp_2int8_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_2int8_mac_ctrl
//  Brief    : Streams INT8 (a,d,b) triples into a dual-product DSP and sums
//             a*b and d*b per vector. Define SAT_ACC_EN to saturate sums.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_2int8_mac_ctrl #(
  parameter int DSP_LAT = 3,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_2int8_mac_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               din_a_q, din_a_d;
  logic [7:0]               din_d_q, din_d_d;
  logic [7:0]               din_b_q, din_b_d;
  logic [DSP_LAT:0]         tag_v_q, tag_v_d;
  logic [DSP_LAT:0]         tag_l_q, tag_l_d;
  logic signed [ACC_W-1:0]  acc_ab_q, acc_ab_d;
  logic signed [ACC_W-1:0]  acc_db_q, acc_db_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     accept;

`ifdef SAT_ACC_EN
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit exposes overflow; clamp toward the sign of the true sum.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [15:0]      prod
  );
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? c_acc_min : c_acc_max;
    return sum[ACC_W-1:0];
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [15:0]      prod
  );
    return acc + (ACC_W)'(prod);
  endfunction
`endif

  always_comb begin
    accept      = bus.in_valid && in_ready_q;
    state_d     = state_q;
    din_a_d     = accept ? bus.in_a : 8'd0;
    din_d_d     = accept ? bus.in_d : 8'd0;
    din_b_d     = accept ? bus.in_b : 8'd0;
    // Tags enter with the operands and reach the top as the products appear.
    tag_v_d     = {tag_v_q[DSP_LAT-1:0], accept};
    tag_l_d     = {tag_l_q[DSP_LAT-1:0], accept && bus.in_last};
    acc_ab_d    = acc_ab_q;
    acc_db_d    = acc_db_q;
    cnt_d       = cnt_q;

    if (tag_v_q[DSP_LAT]) begin
      acc_ab_d = acc_add(acc_ab_q, $signed(bus.dsp_dout_ab));
      acc_db_d = acc_add(acc_db_q, $signed(bus.dsp_dout_db));
      cnt_d    = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept)
          state_d = bus.in_last ? DRAIN : RUN;
      end
      RUN: begin
        if (accept && bus.in_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_v_q[DSP_LAT] && tag_l_q[DSP_LAT])
          state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d  = IDLE;
          acc_ab_d = '0;
          acc_db_d = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE) || (state_d == RUN);
    // out_valid lags DONE entry by a cycle, so a ready already high on entry
    // cannot complete a handshake before the consumer has seen valid.
    out_valid_d = (state_q == DONE) && !(out_valid_q && bus.out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      din_a_q     <= '0;
      din_d_q     <= '0;
      din_b_q     <= '0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
      acc_ab_q    <= '0;
      acc_db_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      din_a_q     <= din_a_d;
      din_d_q     <= din_d_d;
      din_b_q     <= din_b_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
      acc_ab_q    <= acc_ab_d;
      acc_db_q    <= acc_db_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dsp_din_a  = din_a_q;
  assign bus.dsp_din_d  = din_d_q;
  assign bus.dsp_din_b  = din_b_q;
  assign bus.out_acc_ab = acc_ab_q;
  assign bus.out_acc_db = acc_db_q;
  assign bus.out_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_2int8_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_2int8_mac_ctrl
//  Brief    : Two instances (ACC_W 24 and 16) driven with the same directed
//             vectors, each fed by a behavioural DSP and checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_2int8_mac_ctrl;
  localparam int DSP_LAT = 3;
  localparam int CNT_W   = 10;
  localparam int W0      = 24;
  localparam int W1      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_d = '0, in_b = '0;
  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;

  dsp_2int8_mac_ctrl_if #(.ACC_W(W0), .CNT_W(CNT_W)) bus_a ();
  dsp_2int8_mac_ctrl_if #(.ACC_W(W1), .CNT_W(CNT_W)) bus_b ();

  assign bus_a.in_valid = in_valid;  assign bus_b.in_valid = in_valid;
  assign bus_a.in_a     = in_a;      assign bus_b.in_a     = in_a;
  assign bus_a.in_d     = in_d;      assign bus_b.in_d     = in_d;
  assign bus_a.in_b     = in_b;      assign bus_b.in_b     = in_b;
  assign bus_a.in_last  = in_last;   assign bus_b.in_last  = in_last;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

  dsp_2int8_mac_ctrl #(.DSP_LAT(DSP_LAT), .ACC_W(W0), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  dsp_2int8_mac_ctrl #(.DSP_LAT(DSP_LAT), .ACC_W(W1), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Behavioural DSP: products appear DSP_LAT cycles after operands, no reset.
  function automatic logic signed [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] xe, ye;
    xe = $signed({{8{x[7]}}, x});
    ye = $signed({{8{y[7]}}, y});
    return xe * ye;
  endfunction

  logic signed [15:0] pab [2][DSP_LAT];
  logic signed [15:0] pdb [2][DSP_LAT];
  always @(posedge clk) begin
    pab[0][0] <= mul8(bus_a.dsp_din_a, bus_a.dsp_din_b);
    pdb[0][0] <= mul8(bus_a.dsp_din_d, bus_a.dsp_din_b);
    pab[1][0] <= mul8(bus_b.dsp_din_a, bus_b.dsp_din_b);
    pdb[1][0] <= mul8(bus_b.dsp_din_d, bus_b.dsp_din_b);
    for (int s = 1; s < DSP_LAT; s++) begin
      for (int k = 0; k < 2; k++) begin
        pab[k][s] <= pab[k][s-1];
        pdb[k][s] <= pdb[k][s-1];
      end
    end
  end
  assign bus_a.dsp_dout_ab = pab[0][DSP_LAT-1];
  assign bus_a.dsp_dout_db = pdb[0][DSP_LAT-1];
  assign bus_b.dsp_dout_ab = pab[1][DSP_LAT-1];
  assign bus_b.dsp_dout_db = pdb[1][DSP_LAT-1];

  // Reduce an exact integer sum to what a w-bit accumulator holds.
  function automatic longint fold(input longint v, input int w);
    longint hi, lo, m, r;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    m  = longint'(1) << w;
`ifdef SAT_ACC_EN
    r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    r = ((v % m) + m) % m;
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  // Transaction-level model: one vector at a time, result due DSP_LAT+2
  // edges after the final acceptance, held until the consumer takes it.
  bit         m_rdy = 1'b0, m_hold = 1'b0, m_empty = 1'b1, m_fresh = 1'b1, m_acc;
  int         m_wait = 0, m_cnt = 0;
  longint     m_ab [2] = '{0, 0};
  longint     m_db [2] = '{0, 0};
  logic [7:0] m_xa = '0, m_xd = '0, m_xb = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy = 1'b0; m_hold = 1'b0; m_empty = 1'b1; m_fresh = 1'b1;
      m_wait = 0; m_cnt = 0;
      m_ab = '{0, 0}; m_db = '{0, 0};
      m_xa = '0; m_xd = '0; m_xb = '0;
    end else begin
      cyc++;
      m_acc = m_rdy && in_valid;
      m_xa  = m_acc ? in_a : 8'd0;
      m_xd  = m_acc ? in_d : 8'd0;
      m_xb  = m_acc ? in_b : 8'd0;
      if (m_hold && out_ready) begin
        m_hold = 1'b0; m_rdy = 1'b1; m_empty = 1'b1;
        m_cnt = 0; m_ab = '{0, 0}; m_db = '{0, 0};
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_hold = 1'b1;
      end
      if (m_fresh) begin
        m_rdy = 1'b1; m_fresh = 1'b0;
      end
      if (m_acc) begin
        m_empty = 1'b0;
        m_cnt++;
        for (int k = 0; k < 2; k++) begin
          m_ab[k] = fold(m_ab[k] + int'($signed(in_a)) * int'($signed(in_b)), (k == 0) ? W0 : W1);
          m_db[k] = fold(m_db[k] + int'($signed(in_d)) * int'($signed(in_b)), (k == 0) ? W0 : W1);
        end
        if (in_last) begin
          m_rdy = 1'b0;
          m_wait = DSP_LAT + 2;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string nm, input int k, input logic rdy, input logic ov,
                          input logic [7:0] xa, input logic [7:0] xd, input logic [7:0] xb,
                          input logic signed [63:0] ab, input logic signed [63:0] db,
                          input logic [CNT_W-1:0] cnt);
    chk({nm, "_in_ready"}, {63'd0, rdy}, {63'd0, m_rdy});
    chk({nm, "_out_valid"}, {63'd0, ov}, {63'd0, m_hold});
    chk({nm, "_din_a"}, {56'd0, xa}, {56'd0, m_xa});
    chk({nm, "_din_d"}, {56'd0, xd}, {56'd0, m_xd});
    chk({nm, "_din_b"}, {56'd0, xb}, {56'd0, m_xb});
    if (m_hold || m_empty) begin
      chk({nm, "_acc_ab"}, ab, m_ab[k]);
      chk({nm, "_acc_db"}, db, m_db[k]);
      chk({nm, "_count"}, {{(64-CNT_W){1'b0}}, cnt}, 64'(m_cnt % (1 << CNT_W)));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst("a", 0, bus_a.in_ready, bus_a.out_valid, bus_a.dsp_din_a, bus_a.dsp_din_d,
             bus_a.dsp_din_b, $signed(bus_a.out_acc_ab), $signed(bus_a.out_acc_db), bus_a.out_count);
    cmp_inst("b", 1, bus_b.in_ready, bus_b.out_valid, bus_b.dsp_din_a, bus_b.dsp_din_d,
             bus_b.dsp_din_b, $signed(bus_b.out_acc_ab), $signed(bus_b.out_acc_db), bus_b.out_count);
  end

  // Stimulus tasks run from posedge+1 to posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int a, input int d, input int b, input bit last);
    int n = 0;
    in_valid = 1'b1; in_a = a[7:0]; in_d = d[7:0]; in_b = b[7:0]; in_last = last;
    while (!bus_a.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus_a.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus_a.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!bus_a.out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_valid_timeout: got out_valid=0, expected 1 within 100 cycles", nm);
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_rdy_after_hs"}, {63'd0, bus_a.in_ready}, 64'sd1);
    chk({nm, "_valid_after_hs"}, {63'd0, bus_a.out_valid}, 64'sd0);
  endtask

  task automatic lits(input string nm, input longint ab, input longint db, input int cnt);
    chk({nm, "_a_ab"}, $signed(bus_a.out_acc_ab), ab);
    chk({nm, "_a_db"}, $signed(bus_a.out_acc_db), db);
    chk({nm, "_a_cnt"}, {54'd0, bus_a.out_count}, 64'(cnt));
    chk({nm, "_model_ab"}, m_ab[0], ab);
  endtask

  initial begin
    idle(2);
    chk("reset_in_ready", {63'd0, bus_a.in_ready}, 64'sd0);
    chk("reset_acc_ab", $signed(bus_a.out_acc_ab), 64'sd0);
    rst = 1'b0;
    idle(1);
    chk("ready_after_reset", {63'd0, bus_a.in_ready}, 64'sd1);

    // Single element, extremes of a
    send(-128, -1, 1, 1'b1);
    wait_valid("t1");
    chk("t1_latency", 64'(cyc - acc_cyc), 64'(DSP_LAT + 2));
    lits("t1", -128, -1, 1);
    chk("t1_b_db", $signed(bus_b.out_acc_db), -64'sd1);
    handshake("t1");

    // Four elements back to back
    send(1, 2, 3, 1'b0); send(-4, 5, 6, 1'b0); send(7, -8, 9, 1'b0); send(127, 127, -128, 1'b1);
    wait_valid("t2");
    lits("t2", -16214, -16292, 4);
    chk("t2_b_ab", $signed(bus_b.out_acc_ab), -64'sd16214);
    handshake("t2");

    // Same vector with gaps, consumer stalls five cycles
    send(1, 2, 3, 1'b0); idle(2); send(-4, 5, 6, 1'b0); idle(1);
    send(7, -8, 9, 1'b0); idle(3); send(127, 127, -128, 1'b1);
    wait_valid("t3");
    idle(5);
    chk("t3_rdy_in_done", {63'd0, bus_a.in_ready}, 64'sd0);
    lits("t3", -16214, -16292, 4);
    handshake("t3");

    // Overflow of the 16-bit instance; ready already high when DONE is entered
    send(-128, -128, -128, 1'b0); send(-128, -128, -128, 1'b1);
    out_ready = 1'b1;
    wait_valid("t4");
    chk("t4_latency", 64'(cyc - acc_cyc), 64'(DSP_LAT + 2));
    lits("t4", 32768, 32768, 2);
`ifdef SAT_ACC_EN
    chk("t4_b_ab", $signed(bus_b.out_acc_ab), 64'sd32767);
    chk("t4_b_db", $signed(bus_b.out_acc_db), 64'sd32767);
`else
    chk("t4_b_ab", $signed(bus_b.out_acc_ab), -64'sd32768);
    chk("t4_b_db", $signed(bus_b.out_acc_db), -64'sd32768);
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_valid_after_hs", {63'd0, bus_a.out_valid}, 64'sd0);

    // Reset mid-vector discards in-flight products
    send(1, 2, 3, 1'b0); send(4, 5, 6, 1'b0); idle(1);
    rst = 1'b1;
    #1 chk("t5_rdy_in_reset", {63'd0, bus_a.in_ready}, 64'sd0);
    idle(2);
    rst = 1'b0;
    idle(DSP_LAT + 3);
    chk("t5_no_valid", {63'd0, bus_a.out_valid}, 64'sd0);
    chk("t5_acc_clear", $signed(bus_a.out_acc_ab), 64'sd0);
    send(2, 3, 4, 1'b1);
    wait_valid("t5");
    lits("t5", 8, 12, 1);
    handshake("t5");
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
